// File: rtl/driver_stream_rx_if.sv
// Decoded-command bundle produced by driver_stream_rx.
//   master : the decoder, drives every field
//   slave  : a consumer (checker, register bank, testbench monitor)
// Fields:
//   rx_cmd_valid   one-cycle strobe, a command was decoded
//   rx_cmd         0 WRTGS, 1 LATGS, 2 WRTFC, 3 LINERESET, 4 FCWRTEN, 7 INVALID
//   rx_data        48-bit shift register at decode, first-received bit in [47]
//   rx_nbits       SCLK rises since the previous decode (saturating 255)
//   rx_fc_err      WRTFC seen without a directly preceding FCWRTEN
//   rx_gs_words    grayscale words in the last segment
//   rx_gclk_count  GCLK rises in the last segment (saturating 2047)
interface driver_stream_rx_if;
  logic        rx_cmd_valid;
  logic [2:0]  rx_cmd;
  logic [47:0] rx_data;
  logic [7:0]  rx_nbits;
  logic        rx_fc_err;
  logic [3:0]  rx_gs_words;
  logic [10:0] rx_gclk_count;

  modport master (
    output rx_cmd_valid, rx_cmd, rx_data, rx_nbits, rx_fc_err, rx_gs_words, rx_gclk_count
  );
  modport slave (
    input  rx_cmd_valid, rx_cmd, rx_data, rx_nbits, rx_fc_err, rx_gs_words, rx_gclk_count
  );
endinterface

// File: rtl/driver_stream_rx.sv
// Receive-side decoder for the LED-driver serial stream (SCLK/LAT/SIN/GCLK).
// Oversamples one SIN lane on clk_hse, rebuilds LAT commands and their 48-bit
// payloads, counts grayscale words per segment and, optionally, GCLK rises.
// Optional feature macro: DRIVER_STREAM_RX_GCLK_MON_EN (GCLK segment monitor).
// Ports:
//   clk_hse      sampling clock
//   nrst         asynchronous active-low reset
//   driver_sclk  observed SCLK (async)
//   driver_gclk  observed GCLK (async, used only with the monitor enabled)
//   driver_lat   observed LAT (async)
//   drivers_sin  observed SIN lanes (async)
//   lane_sel     lane to decode, captured only while no command is in progress
//   rx           decoded-command bundle (driver_stream_rx_if.master)
module driver_stream_rx #(
  parameter int LANES = 30
) (
  input  logic             clk_hse,
  input  logic             nrst,
  input  logic             driver_sclk,
  input  logic             driver_gclk,
  input  logic             driver_lat,
  input  logic [LANES-1:0] drivers_sin,
  input  logic [4:0]       lane_sel,
  driver_stream_rx_if.master rx
);

  localparam logic [2:0] CMD_WRTGS     = 3'd0;
  localparam logic [2:0] CMD_LATGS     = 3'd1;
  localparam logic [2:0] CMD_WRTFC     = 3'd2;
  localparam logic [2:0] CMD_LINERESET = 3'd3;
  localparam logic [2:0] CMD_FCWRTEN   = 3'd4;
  localparam logic [2:0] CMD_INVALID   = 3'd7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1F) ? v : v + 5'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic        sclk_p0_q, sclk_p1_q, sclk_p2_q;
  logic        lat_p0_q, lat_p1_q, lat_p2_q;
  logic        sin_p0_q, sin_p1_q;
  logic        sin_sel;
  logic [4:0]  lane_q, lane_d;
  logic [47:0] shreg_q, shreg_d, shreg_inc;
  logic [7:0]  nbits_q, nbits_d, nbits_inc;
  logic [4:0]  lat_cnt_q, lat_cnt_d, lat_cnt_inc;
  logic        fc_unlock_q, fc_unlock_d;
  logic [3:0]  gs_cnt_q, gs_cnt_d;
  logic        vld_q, vld_d;
  logic [2:0]  cmd_q, cmd_d, dec_cmd;
  logic [47:0] data_q, data_d;
  logic [7:0]  onb_q, onb_d;
  logic        err_q, err_d;
  logic [3:0]  gsw_q, gsw_d;
  logic        sclk_rise, lat_fall, lat_eff, seg_end;

  // Lane select is applied ahead of the synchronizer so only one SIN bit is synced.
  assign sin_sel = (32'(lane_q) < LANES) ? drivers_sin[lane_q] : 1'b0;

  // Stage p0/p1: 2-FF synchronizers, p2: history flop for edge detect
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      sclk_p0_q <= 1'b0; sclk_p1_q <= 1'b0; sclk_p2_q <= 1'b0;
      lat_p0_q  <= 1'b0; lat_p1_q  <= 1'b0; lat_p2_q  <= 1'b0;
      sin_p0_q  <= 1'b0; sin_p1_q  <= 1'b0;
    end else begin
      sclk_p0_q <= driver_sclk; sclk_p1_q <= sclk_p0_q; sclk_p2_q <= sclk_p1_q;
      lat_p0_q  <= driver_lat;  lat_p1_q  <= lat_p0_q;  lat_p2_q  <= lat_p1_q;
      sin_p0_q  <= sin_sel;     sin_p1_q  <= sin_p0_q;
    end
  end

  assign sclk_rise = sclk_p1_q & ~sclk_p2_q;
  assign lat_fall  = ~lat_p1_q & lat_p2_q;
  // An SCLK rise landing on the LAT-fall sample still counts as a LAT-high bit.
  assign lat_eff   = lat_p1_q | lat_fall;

  // Shift/count results including the current sample, so a same-cycle decode sees them.
  assign shreg_inc   = sclk_rise ? {shreg_q[46:0], sin_p1_q} : shreg_q;
  assign nbits_inc   = sclk_rise ? sat_inc8(nbits_q) : nbits_q;
  assign lat_cnt_inc = (sclk_rise && lat_eff) ? sat_inc5(lat_cnt_q) : lat_cnt_q;

  always_comb begin
    dec_cmd = CMD_INVALID;
    case (lat_cnt_inc)
      5'd1:    dec_cmd = CMD_WRTGS;
      5'd3:    dec_cmd = CMD_LATGS;
      5'd5:    dec_cmd = CMD_WRTFC;
      5'd7:    dec_cmd = CMD_LINERESET;
      5'd15:   dec_cmd = CMD_FCWRTEN;
      default: dec_cmd = CMD_INVALID;
    endcase
  end

  assign seg_end = lat_fall && ((dec_cmd == CMD_LATGS) || (dec_cmd == CMD_LINERESET));

  always_comb begin
    lane_d      = lane_q;
    shreg_d     = shreg_inc;
    nbits_d     = nbits_inc;
    lat_cnt_d   = lat_cnt_inc;
    fc_unlock_d = fc_unlock_q;
    gs_cnt_d    = gs_cnt_q;
    vld_d       = 1'b0;
    cmd_d       = cmd_q;
    data_d      = data_q;
    onb_d       = onb_q;
    err_d       = err_q;
    gsw_d       = gsw_q;
    if ((lat_cnt_q == 5'd0) && (nbits_q == 8'd0)) begin
      lane_d = lane_sel;
    end
    if (lat_fall) begin
      vld_d       = 1'b1;
      cmd_d       = dec_cmd;
      data_d      = shreg_inc;
      onb_d       = nbits_inc;
      err_d       = (dec_cmd == CMD_WRTFC) && !fc_unlock_q;
      fc_unlock_d = (dec_cmd == CMD_FCWRTEN);
      nbits_d     = 8'd0;
      lat_cnt_d   = 5'd0;
      if (dec_cmd == CMD_WRTGS) begin
        gs_cnt_d = sat_inc4(gs_cnt_q);
      end
      if (seg_end) begin
        gsw_d    = sat_inc4(gs_cnt_q);
        gs_cnt_d = 4'd0;
      end
    end
  end

  // Decode/output register stage
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      lane_q      <= '0;
      shreg_q     <= '0;
      nbits_q     <= '0;
      lat_cnt_q   <= '0;
      fc_unlock_q <= 1'b0;
      gs_cnt_q    <= '0;
      vld_q       <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      onb_q       <= '0;
      err_q       <= 1'b0;
      gsw_q       <= '0;
    end else begin
      lane_q      <= lane_d;
      shreg_q     <= shreg_d;
      nbits_q     <= nbits_d;
      lat_cnt_q   <= lat_cnt_d;
      fc_unlock_q <= fc_unlock_d;
      gs_cnt_q    <= gs_cnt_d;
      vld_q       <= vld_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      onb_q       <= onb_d;
      err_q       <= err_d;
      gsw_q       <= gsw_d;
    end
  end

  assign rx.rx_cmd_valid = vld_q;
  assign rx.rx_cmd       = cmd_q;
  assign rx.rx_data      = data_q;
  assign rx.rx_nbits     = onb_q;
  assign rx.rx_fc_err    = err_q;
  assign rx.rx_gs_words  = gsw_q;

`ifdef DRIVER_STREAM_RX_GCLK_MON_EN
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  logic        gclk_p0_q, gclk_p1_q, gclk_p2_q;
  logic [10:0] gclk_cnt_q, gclk_cnt_d, gclk_cnt_inc;
  logic [10:0] gclk_out_q, gclk_out_d;

  assign gclk_cnt_inc = (gclk_p1_q & ~gclk_p2_q) ? sat_inc11(gclk_cnt_q) : gclk_cnt_q;

  always_comb begin
    gclk_cnt_d = gclk_cnt_inc;
    gclk_out_d = gclk_out_q;
    if (seg_end) begin
      gclk_out_d = gclk_cnt_inc;
      gclk_cnt_d = 11'd0;
    end
  end

  // GCLK synchronizer and segment counter stage
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      gclk_p0_q  <= 1'b0; gclk_p1_q <= 1'b0; gclk_p2_q <= 1'b0;
      gclk_cnt_q <= '0;
      gclk_out_q <= '0;
    end else begin
      gclk_p0_q  <= driver_gclk; gclk_p1_q <= gclk_p0_q; gclk_p2_q <= gclk_p1_q;
      gclk_cnt_q <= gclk_cnt_d;
      gclk_out_q <= gclk_out_d;
    end
  end

  assign rx.rx_gclk_count = gclk_out_q;
`else
  logic unused_gclk;
  assign unused_gclk      = driver_gclk;
  assign rx.rx_gclk_count = '0;
`endif

endmodule

// File: tb/tb_driver_stream_rx.sv
module tb_driver_stream_rx;
  localparam int LANES = 30;
`ifdef DRIVER_STREAM_RX_GCLK_MON_EN
  localparam bit GCLK_MON = 1'b1;
`else
  localparam bit GCLK_MON = 1'b0;
`endif

  logic             clk_hse = 1'b0;
  logic             nrst = 1'b0;
  logic             driver_sclk = 1'b0;
  logic             driver_gclk = 1'b0;
  logic             driver_lat = 1'b0;
  logic [LANES-1:0] drivers_sin = '0;
  logic [4:0]       lane_sel = '0;

  driver_stream_rx_if rx_if ();

  driver_stream_rx #(.LANES(LANES)) dut (
    .clk_hse     (clk_hse),
    .nrst        (nrst),
    .driver_sclk (driver_sclk),
    .driver_gclk (driver_gclk),
    .driver_lat  (driver_lat),
    .drivers_sin (drivers_sin),
    .lane_sel    (lane_sel),
    .rx          (rx_if)
  );

  always #5 clk_hse = ~clk_hse;

  typedef struct {
    logic [2:0]  cmd;
    logic [47:0] data;
    logic [7:0]  nbits;
    logic        fc_err;
    logic [3:0]  gsw;
    logic [10:0] gclk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: counts since the last decode plus held output values.
  int          m_bits, m_latc, m_gs, m_gclk;
  logic [47:0] m_shreg;
  bit          m_flag;
  logic [3:0]  m_gsw;
  logic [10:0] m_gclk_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bits = 0; m_latc = 0; m_gs = 0; m_gclk = 0;
    m_shreg = '0; m_flag = 1'b0; m_gsw = '0; m_gclk_out = '0;
  endtask

  task automatic model_decode();
    exp_t e;
    int   lc;
    lc = (m_latc > 31) ? 31 : m_latc;
    case (lc)
      1:       e.cmd = 3'd0;
      3:       e.cmd = 3'd1;
      5:       e.cmd = 3'd2;
      7:       e.cmd = 3'd3;
      15:      e.cmd = 3'd4;
      default: e.cmd = 3'd7;
    endcase
    e.data   = m_shreg;
    e.nbits  = 8'((m_bits > 255) ? 255 : m_bits);
    e.fc_err = (e.cmd == 3'd2) && !m_flag;
    m_flag   = (e.cmd == 3'd4);
    if (e.cmd == 3'd0) m_gs = (m_gs >= 15) ? 15 : m_gs + 1;
    if (e.cmd == 3'd1 || e.cmd == 3'd3) begin
      m_gsw = 4'((m_gs >= 15) ? 15 : m_gs + 1);
      m_gs  = 0;
      if (GCLK_MON) m_gclk_out = 11'((m_gclk > 2047) ? 2047 : m_gclk);
      m_gclk = 0;
    end
    e.gsw  = m_gsw;
    e.gclk = m_gclk_out;
    exp_q.push_back(e);
    m_bits = 0;
    m_latc = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_hse);
    #1;
  endtask

  task automatic sclk_bit(input logic b, input logic l);
    drivers_sin = LANES'($urandom);
    drivers_sin[lane_sel] = b;
    driver_lat = l;
    cyc(2);
    driver_sclk = 1'b1;
    m_bits++;
    if (l) m_latc++;
    m_shreg = {m_shreg[46:0], b};
    cyc(2);
    driver_sclk = 1'b0;
    cyc(1);
  endtask

  // n bits, LAT high on the last k; last 48 bits come from pat (pat[47] first).
  task automatic send_cmd(input int n, input int k, input logic [47:0] pat);
    logic [5:0] idx;
    logic       b;
    for (int i = 0; i < n; i++) begin
      if (n - 1 - i < 48) begin
        idx = 6'(n - 1 - i);
        b   = pat[idx];
      end else begin
        b = 1'($urandom);
      end
      sclk_bit(b, (i >= n - k));
    end
    if (k == 0) begin
      driver_lat = 1'b1;
      cyc(3);
    end else begin
      cyc(1);
    end
    driver_lat = 1'b0;
    model_decode();
    cyc(4);
  endtask

  task automatic gclk_pulses(input int n);
    repeat (n) begin
      driver_gclk = 1'b1;
      cyc(2);
      driver_gclk = 1'b0;
      cyc(2);
      m_gclk++;
    end
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 64'(rx_if.rx_cmd_valid), 64'd0);
    check({tag, "_data"}, 64'(rx_if.rx_data), 64'd0);
    check({tag, "_fields"}, 64'({rx_if.rx_cmd, rx_if.rx_nbits, rx_if.rx_fc_err,
                                 rx_if.rx_gs_words, rx_if.rx_gclk_count}), 64'd0);
  endtask

  // Monitor: every strobe is matched against the oldest expected decode.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_hse);
      if (nrst && rx_if.rx_cmd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got cmd %0d nbits %0d, expected no strobe",
                   rx_if.rx_cmd, rx_if.rx_nbits);
        end else begin
          e = exp_q.pop_front();
          check("rx_cmd", 64'(rx_if.rx_cmd), 64'(e.cmd));
          check("rx_data", 64'(rx_if.rx_data), 64'(e.data));
          check("rx_nbits", 64'(rx_if.rx_nbits), 64'(e.nbits));
          check("rx_fc_err", 64'(rx_if.rx_fc_err), 64'(e.fc_err));
          check("rx_gs_words", 64'(rx_if.rx_gs_words), 64'(e.gsw));
          check("rx_gclk_count", 64'(rx_if.rx_gclk_count), 64'(e.gclk));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ktab[10];
    int k, n, drain;
    ktab = '{0, 1, 2, 3, 5, 7, 15, 31, 33, 9};
    model_reset();

    // Reset held while every input toggles
    nrst = 1'b0;
    repeat (6) begin
      driver_sclk = 1'($urandom); driver_gclk = 1'($urandom);
      driver_lat  = 1'($urandom); drivers_sin = LANES'($urandom);
      lane_sel    = 5'($urandom);
      cyc(3);
      check_outputs_zero("in_reset");
    end
    driver_sclk = 1'b0; driver_gclk = 1'b0; driver_lat = 1'b0; drivers_sin = '0;
    lane_sel = 5'($urandom_range(0, LANES - 1));
    cyc(3);
    nrst = 1'b1;
    cyc(5);
    check_outputs_zero("after_reset");

    // Configuration write: FCWRTEN then WRTFC
    send_cmd(15, 15, rnd48());
    send_cmd(48, 5, 48'hA5A5_1234_5678);
    // WRTFC without unlock
    send_cmd(48, 5, rnd48());

    // Grayscale segment: 8 WRTGS, 500 GCLK rises, LATGS
    for (int w = 0; w < 8; w++) begin
      send_cmd(48, 1, rnd48());
      gclk_pulses((w == 0) ? 66 : 62);
    end
    send_cmd(48, 3, rnd48());
    cyc(2);
    check("seg_gs_words", 64'(rx_if.rx_gs_words), 64'd9);
    check("seg_gclk_count", 64'(rx_if.rx_gclk_count), GCLK_MON ? 64'd500 : 64'd0);

    // Malformed LAT
    send_cmd(0, 0, rnd48());
    send_cmd(2, 2, rnd48());
    send_cmd(40, 40, rnd48());
    // nbits saturation
    send_cmd(260, 1, rnd48());
    // GCLK counter saturation closed by LINERESET
    gclk_pulses(2100);
    send_cmd(10, 7, rnd48());

    // Randomized commands on random lanes
    repeat (40) begin
      lane_sel = 5'($urandom_range(0, LANES - 1));
      cyc(3);
      k = ktab[$urandom_range(0, 9)];
      n = k + $urandom_range(0, 60);
      if ($urandom_range(0, 1) == 1) gclk_pulses($urandom_range(0, 20));
      send_cmd(n, k, rnd48());
    end

    // Reset in the middle of a LAT-high run
    for (int i = 0; i < 20; i++) sclk_bit(1'($urandom), 1'b1);
    nrst = 1'b0;
    cyc(2);
    driver_lat = 1'b0;
    cyc(2);
    model_reset();
    nrst = 1'b1;
    cyc(4);
    send_cmd(48, 1, rnd48());

    drain = 0;
    while (exp_q.size() != 0 && drain < 50) begin
      cyc(1);
      drain++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
